// File: rtl/freq_bcd_converter.sv
// ---------------------------------------------------------------------------
// freq_bcd_converter
//
// Converts the frequency counter's binary measurement result into packed BCD
// using iterative shift-and-add-3 (double dabble), one input bit per clock.
// It also produces a leading-zero blank mask and a significant-digit count
// for the display / UART formatting stage.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     one-cycle start strobe (calculation_done)
//   in_data      unsigned value to convert (frequency_out)
//   busy         conversion in progress; new strobes are dropped while high
//   out_valid    one-cycle pulse marking freshly updated result outputs
//   bcd_out      packed BCD, digit 0 (units) in bits [3:0]
//   blank_mask   bit i set when digit i is a leading zero (bit 0 never set)
//   digit_count  number of significant digits, 1..DIGITS
//   drop_count   strobes ignored because busy, saturating at 255
// ---------------------------------------------------------------------------
module freq_bcd_converter #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [WIDTH-1:0]    in_data,
   output logic                busy,
   output logic                out_valid,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic [DIGITS-1:0]   blank_mask,
   output logic [3:0]          digit_count,
   output logic [7:0]          drop_count
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   // Idle display shows a single "0": every digit blanked except the units.
   localparam logic [DIGITS-1:0] MASK_RST = ~DIGITS'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    bin_reg;
   logic [4*DIGITS-1:0] acc_reg;
   logic [4*DIGITS-1:0] acc_adj;
   logic [CNT_W-1:0]    cnt_reg;
   logic                accept;
   logic                shift_en;
   logic                done_en;
   logic                last_step;
   logic                zero_run;
   logic [DIGITS-1:0]   mask_next;
   logic [3:0]          count_next;

   assign busy      = (state_reg != IDLE);
   assign last_step = (cnt_reg == CNT_W'(1));

   // Add-3 correction for every digit that would overflow past 9 after the
   // upcoming doubling.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] d;
         assign d = acc_reg[4*gi +: 4];
         assign acc_adj[4*gi +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
      end
   endgenerate

   // Leading-zero scan from the most significant digit downward; the run of
   // zeros ends at the first non-zero digit. Digit 0 is never part of it.
   always_comb begin
      mask_next  = '0;
      count_next = 4'(DIGITS);
      zero_run   = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run && (acc_reg[4*i +: 4] == 4'd0);
         mask_next[i] = zero_run;
         if (zero_run) begin
            count_next = count_next - 4'd1;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next state and datapath controls
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      shift_en   = 1'b0;
      done_en    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done_en    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_reg     <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         out_valid   <= 1'b0;
         bcd_out     <= '0;
         blank_mask  <= MASK_RST;
         digit_count <= 4'd1;
         drop_count  <= 8'd0;
      end else begin
         out_valid <= done_en;

         if (accept) begin
            bin_reg <= in_data;
            acc_reg <= '0;
            cnt_reg <= CNT_W'(WIDTH);
         end else if (shift_en) begin
            // Binary MSB moves into accumulator bit 0.
            {acc_reg, bin_reg} <= {acc_adj, bin_reg} << 1;
            cnt_reg            <= cnt_reg - CNT_W'(1);
         end

         if (done_en) begin
            bcd_out     <= acc_reg;
            blank_mask  <= mask_next;
            digit_count <= count_next;
         end

         // A strobe arriving while busy cannot be queued; record it instead.
         if (in_valid && busy && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_freq_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_freq_bcd_converter
//
// Self-checking bench for freq_bcd_converter with default parameters.
// Expected results come from decimal arithmetic (repeated divide by 10) on
// the input value, plus literal values for the fixed test-plan cases.
// ---------------------------------------------------------------------------
module tb_freq_bcd_converter;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 10;
   localparam int LAT    = WIDTH + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic [WIDTH-1:0]    in_data;
   logic                busy;
   logic                out_valid;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   blank_mask;
   logic [3:0]          digit_count;
   logic [7:0]          drop_count;

   int checks   = 0;
   int failures = 0;
   int exp_drop = 0;

   // Fixed cases with hand-derived expectations.
   logic [WIDTH-1:0]    kv_val  [6] = '{32'd0, 32'd1000, 32'hFFFFFFFF, 32'd9, 32'd10, 32'd99999};
   logic [4*DIGITS-1:0] kv_bcd  [6] = '{40'h0, 40'h1000, 40'h4294967295, 40'h9, 40'h10, 40'h99999};
   logic [DIGITS-1:0]   kv_mask [6] = '{10'b1111111110, 10'b1111110000, 10'b0000000000,
                                        10'b1111111110, 10'b1111111100, 10'b1111100000};
   logic [3:0]          kv_cnt  [6] = '{4'd1, 4'd4, 4'd10, 4'd1, 4'd2, 4'd5};

   freq_bcd_converter #(
      .WIDTH (WIDTH),
      .DIGITS(DIGITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .busy       (busy),
      .out_valid  (out_valid),
      .bcd_out    (bcd_out),
      .blank_mask (blank_mask),
      .digit_count(digit_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [4*DIGITS-1:0] ref_bcd(input longint unsigned v);
      logic [4*DIGITS-1:0] r;
      r = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int ref_count(input longint unsigned v);
      int n;
      n = 1;
      while (v >= 10) begin
         v = v / 10;
         n++;
      end
      return n;
   endfunction

   function automatic logic [DIGITS-1:0] ref_mask(input longint unsigned v);
      logic [DIGITS-1:0] m;
      int n;
      m = '0;
      n = ref_count(v);
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= n) m[i] = 1'b1;
      end
      return m;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   // Called just after a clock edge; returns just after the accepting edge.
   task automatic start_conv(input logic [WIDTH-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts cycles (and busy-high samples, including the current one) until
   // out_valid, bounded at 200 cycles.
   task automatic wait_out(output int cycles, output int busy_n);
      cycles = 0;
      busy_n = busy ? 1 : 0;
      while (!out_valid && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (busy) busy_n++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags busy=%b out_valid=%b required 0 0", busy, out_valid);
      end
      checks++;
      if (bcd_out !== '0 || blank_mask !== 10'b1111111110 || digit_count !== 4'd1 || drop_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_values bcd=%h mask=%b cnt=%0d drop=%0d required 0 1111111110 1 0",
                  bcd_out, blank_mask, digit_count, drop_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || digit_count !== 4'd1) begin
         failures++;
         $display("FAIL reset_release busy=%b out_valid=%b cnt=%0d required 0 0 1", busy, out_valid, digit_count);
      end
      $display("reset: released");
   endtask

   task automatic test_known_values();
      int cyc, bn;
      for (int k = 0; k < 6; k++) begin
         start_conv(kv_val[k]);
         wait_out(cyc, bn);
         checks++;
         if (cyc !== LAT) begin
            failures++;
            $display("FAIL known_latency val=%0d got=%0d required=%0d", kv_val[k], cyc, LAT);
         end
         checks++;
         if (bn !== LAT) begin
            failures++;
            $display("FAIL known_busy_cycles val=%0d got=%0d required=%0d", kv_val[k], bn, LAT);
         end
         checks++;
         if (bcd_out !== kv_bcd[k] || bcd_out !== ref_bcd(kv_val[k])) begin
            failures++;
            $display("FAIL known_bcd val=%0d got=%h required=%h", kv_val[k], bcd_out, kv_bcd[k]);
         end
         checks++;
         if (blank_mask !== kv_mask[k] || digit_count !== kv_cnt[k]) begin
            failures++;
            $display("FAIL known_mask_count val=%0d got=%b/%0d required=%b/%0d",
                     kv_val[k], blank_mask, digit_count, kv_mask[k], kv_cnt[k]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0 || bcd_out !== kv_bcd[k]) begin
            failures++;
            $display("FAIL known_hold val=%0d out_valid=%b bcd=%h required 0 %h",
                     kv_val[k], out_valid, bcd_out, kv_bcd[k]);
         end
         $display("known: in=%0d bcd=%h mask=%b count=%0d lat=%0d", kv_val[k], bcd_out, blank_mask, digit_count, cyc);
      end
   endtask

   task automatic test_random();
      int cyc, bn;
      logic [WIDTH-1:0] v;
      for (int k = 0; k < 12; k++) begin
         v = WIDTH'($urandom) >> $urandom_range(0, 31);
         start_conv(v);
         wait_out(cyc, bn);
         checks++;
         if (cyc !== LAT) begin
            failures++;
            $display("FAIL rand_latency val=%0d got=%0d required=%0d", v, cyc, LAT);
         end
         checks++;
         if (bcd_out !== ref_bcd(v)) begin
            failures++;
            $display("FAIL rand_bcd val=%0d got=%h required=%h", v, bcd_out, ref_bcd(v));
         end
         checks++;
         if (blank_mask !== ref_mask(v) || digit_count !== 4'(ref_count(v))) begin
            failures++;
            $display("FAIL rand_mask_count val=%0d got=%b/%0d required=%b/%0d",
                     v, blank_mask, digit_count, ref_mask(v), ref_count(v));
         end
         $display("random: in=%0d bcd=%h mask=%b count=%0d", v, bcd_out, blank_mask, digit_count);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bn;
      start_conv(32'd12345);
      repeat (4) @(posedge clk);
      #1;
      start_conv(32'd999);              // lands mid-conversion: dropped
      exp_drop++;
      cyc = 5;
      while (!out_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc !== LAT || bcd_out !== ref_bcd(12345)) begin
         failures++;
         $display("FAIL overlap_result lat=%0d bcd=%h required %0d %h", cyc, bcd_out, LAT, ref_bcd(12345));
      end
      checks++;
      if (drop_count !== 8'(exp_drop)) begin
         failures++;
         $display("FAIL overlap_drop got=%0d required=%0d", drop_count, exp_drop);
      end
      $display("overlap: bcd=%h drop=%0d", bcd_out, drop_count);
      // Strobe in the out_valid cycle itself must be accepted.
      start_conv(32'd777);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept busy=%b required 1", busy);
      end
      wait_out(cyc, bn);
      checks++;
      if (cyc !== LAT || bcd_out !== 40'h777 || digit_count !== 4'd3) begin
         failures++;
         $display("FAIL b2b_result lat=%0d bcd=%h cnt=%0d required %0d 777 3", cyc, bcd_out, digit_count, LAT);
      end
      checks++;
      if (drop_count !== 8'(exp_drop)) begin
         failures++;
         $display("FAIL b2b_drop got=%0d required=%0d", drop_count, exp_drop);
      end
      $display("back_to_back: bcd=%h lat=%0d drop=%0d", bcd_out, cyc, drop_count);
      @(posedge clk);
      #1;
   endtask

   task automatic test_saturation();
      int cyc, bn, drops;
      drops = 0;
      // in_valid held high: one acceptance every WIDTH+2 samples, the rest drop.
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      for (int k = 0; k < 400; k++) begin
         if (k % (WIDTH + 2) != 0) drops++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      exp_drop = (exp_drop + drops > 255) ? 255 : exp_drop + drops;
      wait_out(cyc, bn);
      checks++;
      if (cyc >= 200) begin
         failures++;
         $display("FAIL sat_timeout cycles=%0d required <200", cyc);
      end
      checks++;
      if (drop_count !== 8'(exp_drop)) begin
         failures++;
         $display("FAIL sat_drop got=%0d required=%0d", drop_count, exp_drop);
      end
      $display("saturation: drops_driven=%0d drop_count=%0d", drops, drop_count);
      @(posedge clk);
      #1;
   endtask

   task automatic test_mid_reset();
      int cyc, bn, seen;
      start_conv(32'd50000000);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_drop = 0;
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || bcd_out !== '0 || blank_mask !== 10'b1111111110 ||
          digit_count !== 4'd1 || drop_count !== 8'd0) begin
         failures++;
         $display("FAIL midrst_values busy=%b ov=%b bcd=%h mask=%b cnt=%0d drop=%0d required reset values",
                  busy, out_valid, bcd_out, blank_mask, digit_count, drop_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL midrst_no_output activity_cycles=%0d required=0", seen);
      end
      start_conv(32'd50000000);
      wait_out(cyc, bn);
      checks++;
      if (cyc !== LAT || bcd_out !== 40'h0050000000 || digit_count !== 4'd8 || blank_mask !== 10'b1100000000) begin
         failures++;
         $display("FAIL midrst_fresh lat=%0d bcd=%h cnt=%0d mask=%b required %0d 0050000000 8 1100000000",
                  cyc, bcd_out, digit_count, blank_mask, LAT);
      end
      checks++;
      if (drop_count !== 8'(exp_drop)) begin
         failures++;
         $display("FAIL midrst_drop got=%0d required=%0d", drop_count, exp_drop);
      end
      $display("mid_reset: fresh bcd=%h count=%0d", bcd_out, digit_count);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_known_values();
      test_random();
      test_back_to_back();
      test_saturation();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
